// File: rtl/hex_word_pkg.sv
// rtl/hex_word_pkg.sv - shared word table, selector mask, state enum and frame type for the HEX word path
package hex_word_pkg;

  localparam int HEX_DIGITS = 6;
  localparam int SEG_W      = 7;

  // Packed frame: index 0 is HEX0 (first digit received), index 5 is HEX5
  typedef logic [HEX_DIGITS-1:0][SEG_W-1:0] frame_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // All six digits dark
  localparam frame_t BLANK = '0;

  // Selectors that own a table word; 011 and 110 have none
  localparam logic [7:0] VALID_SEL_MASK = 8'b1011_0111;

  // Active-high segment patterns indexed by selector, written {HEX5 .. HEX0}
  localparam frame_t WORD_TABLE [0:7] = '{
    {7'h00, 7'h5B, 7'h4F, 7'h7E, 7'h37, 7'h5B},  // 000
    {7'h00, 7'h00, 7'h4F, 7'h4F, 7'h0E, 7'h5E},  // 001
    {7'h00, 7'h5B, 7'h0E, 7'h0E, 7'h77, 7'h7F},  // 010
    {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},  // 011 (no word)
    {7'h00, 7'h00, 7'h47, 7'h47, 7'h3E, 7'h4E},  // 100
    {7'h00, 7'h00, 7'h6D, 7'h6D, 7'h3E, 7'h47},  // 101
    {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},  // 110 (no word)
    {7'h00, 7'h5B, 7'h37, 7'h4E, 7'h7E, 7'h5B}   // 111
  };

endpackage

// File: rtl/hex_word_match.sv
// rtl/hex_word_match.sv - combinational compare of a buffered frame against the word table
module hex_word_match
  import hex_word_pkg::*;
(
  input  frame_t      frame,
  output logic        hit,
  output logic [2:0]  code,
  output logic        blank
);

  // Parallel compare; scanning from the top down lets the lowest selector win
  always_comb begin
    hit   = 1'b0;
    code  = 3'b000;
    for (int s = 7; s >= 0; s--) begin
      if (VALID_SEL_MASK[s] && (frame == WORD_TABLE[s])) begin
        hit  = 1'b1;
        code = 3'(s);
      end
    end
    blank = (frame == BLANK);
  end

endmodule

// File: rtl/hex_word_decoder.sv
// rtl/hex_word_decoder.sv - collects six 7-segment digits and decodes them back to a selector code
module hex_word_decoder
  import hex_word_pkg::*;
#(
  parameter int NUM_DIGITS = HEX_DIGITS,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seg_valid,
  input  logic [6:0]       seg_in,
  output logic             seg_ready,
  input  logic             abort,
  output logic             done,
  output logic [2:0]       code,
  output logic             match,
  output logic             blank,
  output logic [CNT_W-1:0] mismatch_cnt
);

  state_t      state, state_nxt;
  logic [2:0]  idx;
  frame_t      frame_q;
  logic        accept;
  logic        last_digit;
  logic        m_hit;
  logic [2:0]  m_code;
  logic        m_blank;

  hex_word_match u_match (
    .frame (frame_q),
    .hit   (m_hit),
    .code  (m_code),
    .blank (m_blank)
  );

  assign accept     = (state == COLLECT) && seg_valid && !abort;
  assign last_digit = (idx == 3'(NUM_DIGITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  // Next state and ready: only COLLECT takes digits; abort in CHECK drops the frame
  always_comb begin
    state_nxt = state;
    seg_ready = 1'b0;
    case (state)
      COLLECT: begin
        seg_ready = 1'b1;
        if (accept && last_digit) state_nxt = CHECK;
      end
      CHECK:   state_nxt = abort ? COLLECT : REPORT;
      REPORT:  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Digit buffer and index: abort clears the partial frame, accepts store active-high
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      frame_q <= '0;
    end else if (state == COLLECT) begin
      if (abort) begin
        idx     <= '0;
        frame_q <= '0;
      end else if (seg_valid) begin
        frame_q[idx] <= ~seg_in;
        idx          <= last_digit ? 3'd0 : idx + 3'd1;
      end
    end
  end

  // Result registers update on the CHECK-to-REPORT edge and hold until the next report
  always_ff @(posedge clk) begin
    if (reset) begin
      done         <= 1'b0;
      code         <= 3'b000;
      match        <= 1'b0;
      blank        <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == CHECK && !abort) begin
        done  <= 1'b1;
        match <= m_hit;
        code  <= m_hit ? m_code : 3'b000;
        blank <= !m_hit && m_blank;
        if (!m_hit && !m_blank && (mismatch_cnt != '1))
          mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_word_decoder.sv
// tb/tb_hex_word_decoder.sv - directed self-checking bench for hex_word_decoder
module tb_hex_word_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       seg_valid;
  logic [6:0] seg_in;
  logic       seg_ready;
  logic       abort;
  logic       done;
  logic [2:0] code;
  logic       match;
  logic       blank;
  logic [7:0] mismatch_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Active-low digit streams, written {HEX5 .. HEX0}
  localparam logic [41:0] F000  = {7'h7F, 7'h24, 7'h30, 7'h01, 7'h48, 7'h24};
  localparam logic [41:0] F001  = {7'h7F, 7'h7F, 7'h30, 7'h30, 7'h71, 7'h21};
  localparam logic [41:0] F001X = {7'h7F, 7'h7F, 7'h31, 7'h30, 7'h71, 7'h21};
  localparam logic [41:0] F010  = {7'h7F, 7'h24, 7'h71, 7'h71, 7'h08, 7'h00};
  localparam logic [41:0] F100  = {7'h7F, 7'h7F, 7'h38, 7'h38, 7'h41, 7'h31};
  localparam logic [41:0] F101  = {7'h7F, 7'h7F, 7'h12, 7'h12, 7'h41, 7'h38};
  localparam logic [41:0] F111  = {7'h7F, 7'h24, 7'h48, 7'h31, 7'h01, 7'h24};
  localparam logic [41:0] FBLK  = {6{7'h7F}};

  hex_word_decoder #(.NUM_DIGITS(6), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_valid    (seg_valid),
    .seg_in       (seg_in),
    .seg_ready    (seg_ready),
    .abort        (abort),
    .done         (done),
    .code         (code),
    .match        (match),
    .blank        (blank),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive the first n digits of a frame, one per edge; leaves the sample point after the last accept
  task automatic send_digits(input logic [41:0] f, input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      seg_valid = 1'b1;
      seg_in    = f[i*7 +: 7];
      step();
    end
    if (hold) seg_in = 7'h7F;
    else      seg_valid = 1'b0;
  endtask

  task automatic test_reset();
    if (seg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", seg_ready); end
    checks++;
    if ({done, code, match, blank} !== 6'b0) begin
      errors++; $display("FAIL rst_outs got done=%b code=%b match=%b blank=%b want all 0", done, code, match, blank);
    end
    checks++;
    if (mismatch_cnt !== 8'h00) begin errors++; $display("FAIL rst_cnt got %h want 00", mismatch_cnt); end
    checks++;
  endtask

  task automatic test_basic_001();
    int d0;
    d0 = done_cnt;
    send_digits(F001, 6, 1'b1);
    if (seg_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL t1_check_cycle got ready=%b done=%b want 0 0", seg_ready, done);
    end
    checks++;
    step();
    if (seg_ready !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL t1_report_cycle got ready=%b done=%b want 0 1", seg_ready, done);
    end
    checks++;
    if (code !== 3'b001 || match !== 1'b1 || blank !== 1'b0 || mismatch_cnt !== 8'h00) begin
      errors++; $display("FAIL t1_result got code=%b match=%b blank=%b cnt=%h want 001 1 0 00", code, match, blank, mismatch_cnt);
    end
    checks++;
    seg_valid = 1'b0;
    step();
    if (seg_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t1_back_to_collect got ready=%b done=%b want 1 0", seg_ready, done);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t1_done_count got %0d want 1", done_cnt - d0); end
    checks++;
  endtask

  task automatic test_word_000();
    send_digits(F000, 6, 1'b0);
    step();
    if (code !== 3'b000 || match !== 1'b1 || blank !== 1'b0) begin
      errors++; $display("FAIL t2_word000 got code=%b match=%b blank=%b want 000 1 0", code, match, blank);
    end
    checks++;
    step();
  endtask

  task automatic test_blank();
    send_digits(FBLK, 6, 1'b0);
    step();
    if (code !== 3'b000 || match !== 1'b0 || blank !== 1'b1 || mismatch_cnt !== 8'h00) begin
      errors++; $display("FAIL t3_blank got code=%b match=%b blank=%b cnt=%h want 000 0 1 00", code, match, blank, mismatch_cnt);
    end
    checks++;
    step();
    if (blank !== 1'b1) begin errors++; $display("FAIL t3_hold got blank=%b want 1", blank); end
    checks++;
  endtask

  task automatic test_mismatch_saturate();
    send_digits(F001X, 6, 1'b0);
    step();
    if (match !== 1'b0 || blank !== 1'b0 || code !== 3'b000 || mismatch_cnt !== 8'h01) begin
      errors++; $display("FAIL t4_first got match=%b blank=%b code=%b cnt=%h want 0 0 000 01", match, blank, code, mismatch_cnt);
    end
    checks++;
    step();
    for (int k = 0; k < 253; k++) begin
      send_digits(F001X, 6, 1'b0);
      step(); step();
    end
    if (mismatch_cnt !== 8'hFE) begin errors++; $display("FAIL t4_cnt254 got %h want fe", mismatch_cnt); end
    checks++;
    send_digits(F001X, 6, 1'b0);
    step(); step();
    if (mismatch_cnt !== 8'hFF) begin errors++; $display("FAIL t4_cnt255 got %h want ff", mismatch_cnt); end
    checks++;
    for (int k = 0; k < 45; k++) begin
      send_digits(F001X, 6, 1'b0);
      step(); step();
    end
    if (mismatch_cnt !== 8'hFF) begin errors++; $display("FAIL t4_saturate got %h want ff", mismatch_cnt); end
    checks++;
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    send_digits(F001, 3, 1'b0);
    abort = 1'b1;
    seg_valid = 1'b1;
    seg_in = 7'h30;
    step();
    abort = 1'b0;
    seg_valid = 1'b0;
    send_digits(F010, 6, 1'b0);
    step();
    if (code !== 3'b010 || match !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL t5_after_abort got code=%b match=%b done=%b want 010 1 1", code, match, done);
    end
    checks++;
    step();
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t5_done_count got %0d want 1", done_cnt - d0); end
    checks++;
    d0 = done_cnt;
    send_digits(F000, 6, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (seg_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t5_check_abort got ready=%b done=%b want 1 0", seg_ready, done);
    end
    checks++;
    step(); step();
    if (done_cnt - d0 !== 0 || code !== 3'b010 || match !== 1'b1) begin
      errors++; $display("FAIL t5_cancelled got dones=%0d code=%b match=%b want 0 010 1", done_cnt - d0, code, match);
    end
    checks++;
    if (mismatch_cnt !== 8'hFF) begin errors++; $display("FAIL t5_cnt_kept got %h want ff", mismatch_cnt); end
    checks++;
  endtask

  task automatic test_back_to_back();
    send_digits(F100, 6, 1'b0);
    step();
    if (code !== 3'b100 || match !== 1'b1) begin
      errors++; $display("FAIL b2b_word100 got code=%b match=%b want 100 1", code, match);
    end
    checks++;
    step();
    send_digits(F101, 6, 1'b0);
    step();
    if (code !== 3'b101 || match !== 1'b1) begin
      errors++; $display("FAIL b2b_word101 got code=%b match=%b want 101 1", code, match);
    end
    checks++;
    step();
  endtask

  task automatic test_reset_mid_frame();
    send_digits(F000, 4, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    if (seg_ready !== 1'b1 || {done, code, match, blank} !== 6'b0 || mismatch_cnt !== 8'h00) begin
      errors++; $display("FAIL t6_reset got ready=%b done=%b code=%b match=%b blank=%b cnt=%h want 1 0 000 0 0 00",
                         seg_ready, done, code, match, blank, mismatch_cnt);
    end
    checks++;
    send_digits(F111, 6, 1'b0);
    step();
    if (code !== 3'b111 || match !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL t6_word111 got code=%b match=%b done=%b want 111 1 1", code, match, done);
    end
    checks++;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    seg_valid = 1'b0;
    seg_in    = 7'h7F;
    abort     = 1'b0;
    step(); step();
    reset = 1'b0;
    test_reset();
    test_basic_001();
    test_word_000();
    test_blank();
    test_mismatch_saturate();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
